axi_rd_arbiter: RTL and testbench

- Parametrised AXI4 read-address/read-data arbiter: NUM_CH requesters (I-cache, D-cache, uncached ports, later TLB walker) share one AXI read port.
- Successor to the fixed two-way, data-first read mux: per-channel burst length/size/type, registered AR signals, rid-tagged routing, beat checking, and selectable round-robin or fixed priority.
- Exactly one transaction outstanding. Sits between the MMU channel controllers and the AXI crossbar.

---
 rtl/axi_pkg.sv | 19 +
 rtl/rr_pick.sv | 35 +++
 rtl/axi_rd_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI read-channel constants and the read-arbiter state encoding.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational find-first-set over a request vector, searching upward from ptr_i
// and wrapping; a constant-zero pointer degenerates to fixed lowest-index priority.
module rr_pick #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_CH)) sum = sum - (IDX_W+1)'(NUM_CH);
      cand = sum[IDX_W-1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// NUM_CH-way AXI4 read arbiter, one transaction outstanding, rid-checked routing.
// Define AXI_RD_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (ch0 highest).
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*8-1:0]      req_len,
  input  logic [NUM_CH*3-1:0]      req_size,
  input  logic [NUM_CH*2-1:0]      req_burst,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [DATA_W-1:0]        resp_data,
  output logic [NUM_CH-1:0]        resp_valid,
  output logic [NUM_CH-1:0]        resp_last,
  output logic [NUM_CH-1:0]        resp_err,
  output logic                     proto_err,
  output logic [ID_W-1:0]          arid,
  output logic [ADDR_W-1:0]        araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [ID_W-1:0]          rid,
  input  logic [DATA_W-1:0]        rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = 9;

  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [7:0]        len_a   [NUM_CH];
  logic [2:0]        size_a  [NUM_CH];
  logic [1:0]        burst_a [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign len_a[i]   = req_len[i*8 +: 8];
    assign size_a[i]  = req_size[i*3 +: 3];
    assign burst_a[i] = req_burst[i*2 +: 2];
  end

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [1:0]        arburst_q, arburst_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic              perr_q, perr_d;

  logic [NUM_CH-1:0] gnt;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  ptr;

`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_i  (req_valid),
    .ptr_i  (ptr),
    .gnt_o  (gnt),
    .idx_o  (win_idx)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    beat_d    = beat_q;
    perr_d    = perr_q;
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (rvalid) perr_d = 1'b1;
        if (|req_valid) begin
          araddr_d  = addr_a[win_idx];
          arlen_d   = len_a[win_idx];
          arsize_d  = size_a[win_idx];
          arburst_d = burst_a[win_idx];
          arid_d    = ID_W'(win_idx);
          owner_d   = win_idx;
          state_d   = ADDR;
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
          ptr_d     = (win_idx == IDX_W'(NUM_CH-1)) ? '0 : win_idx + 1'b1;
`endif
        end
      end
      ADDR: begin
        if (rvalid) perr_d = 1'b1;
        if (arready) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (rvalid) begin
          beat_d = beat_q + 1'b1;
          if (rid != arid_q) perr_d = 1'b1;
          if (rlast) begin
            if (beat_q != {1'b0, arlen_q}) perr_d = 1'b1;
            state_d = IDLE;
          end else if (beat_q >= {1'b0, arlen_q}) begin
            // Slave overran the burst without rlast: abandon rather than hang.
            perr_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      beat_q    <= '0;
      perr_q    <= 1'b0;
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      beat_q    <= beat_d;
      perr_q    <= perr_d;
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign arid      = arid_q;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsize    = arsize_q;
  assign arburst   = arburst_q;
  assign arvalid   = (state_q == ADDR);
  assign rready    = (state_q == DATA);
  assign proto_err = perr_q;
  assign resp_data = (state_q == DATA) ? rdata : '0;

  // Accept pulse is masked while rst is high so every output reads 0 during reset.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_last  = '0;
    resp_err   = '0;
    if (state_q == IDLE && !rst) req_ready = gnt;
    if (state_q == DATA) begin
      resp_valid[owner_q] = rvalid;
      resp_last[owner_q]  = rvalid && rlast;
      resp_err[owner_q]   = rvalid && (rresp != OKAY);
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter (two channels); contention order follows AXI_RD_ARB_ROUND_ROBIN_EN.
module tb_axi_rd_arbiter;
  import axi_pkg::*;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*8-1:0]      req_len;
  logic [NUM_CH*3-1:0]      req_size;
  logic [NUM_CH*2-1:0]      req_burst;
  logic [NUM_CH-1:0]        req_ready;
  logic [DATA_W-1:0]        resp_data;
  logic [NUM_CH-1:0]        resp_valid;
  logic [NUM_CH-1:0]        resp_last;
  logic [NUM_CH-1:0]        resp_err;
  logic                     proto_err;
  logic [ID_W-1:0]          arid;
  logic [ADDR_W-1:0]        araddr;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic                     arvalid;
  logic                     arready;
  logic [ID_W-1:0]          rid;
  logic [DATA_W-1:0]        rdata;
  logic [1:0]               rresp;
  logic                     rlast;
  logic                     rvalid;
  logic                     rready;

  int n_tests = 0;
  int n_fail  = 0;

  axi_rd_arbiter #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_size   (req_size),
    .req_burst  (req_burst),
    .req_ready  (req_ready),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .resp_last  (resp_last),
    .resp_err   (resp_err),
    .proto_err  (proto_err),
    .arid       (arid),
    .araddr     (araddr),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .arvalid    (arvalid),
    .arready    (arready),
    .rid        (rid),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .rvalid     (rvalid),
    .rready     (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    req_valid = '0; req_addr = '0; req_len = '0; req_size = '0; req_burst = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = OKAY; rlast = 1'b0; rvalid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b);
    req_valid[ch]          = 1'b1;
    req_addr[ch*32 +: 32]  = a;
    req_len[ch*8 +: 8]     = l;
    req_size[ch*3 +: 3]    = s;
    req_burst[ch*2 +: 2]   = b;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    req_valid = 2'b11;
    rvalid = 1'b1;
    #1;
    n_tests++;
    if ({req_ready, resp_valid, resp_last, resp_err, resp_data, proto_err, arvalid, rready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req_ready=%b resp_valid=%b resp_data=%h proto_err=%b arvalid=%b rready=%b, want all 0",
               req_ready, resp_valid, resp_data, proto_err, arvalid, rready);
    end
    n_tests++;
    if ({arid, araddr, arlen, arsize, arburst} !== '0) begin
      n_fail++;
      $display("FAIL reset_ar_regs: got %h, want 0", {arid, araddr, arlen, arsize, arburst});
    end
    do_reset();
  endtask

  task automatic test_single_burst();
    do_reset();
    set_req(1, 32'h1FC0_0000, 8'd15, 3'd2, BURST_INCR);
    #1;
    n_tests++;
    if ({req_ready, arvalid} !== {2'b10, 1'b0}) begin
      n_fail++;
      $display("FAIL single_grant: req_ready=%b arvalid=%b, want 10/0", req_ready, arvalid);
    end
    step();
    req_valid = '0;
    #1;
    n_tests++;
    if ({arvalid, arid, araddr, arlen, arsize, arburst} !== {1'b1, 4'd1, 32'h1FC0_0000, 8'd15, 3'd2, BURST_INCR}) begin
      n_fail++;
      $display("FAIL single_ar_fields: got %h, want %h", {arvalid, arid, araddr, arlen, arsize, arburst},
               {1'b1, 4'd1, 32'h1FC0_0000, 8'd15, 3'd2, BURST_INCR});
    end
    step();
    arready = 1'b1;
    #1;
    n_tests++;
    if ({arvalid, req_ready} !== {1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL single_ar_hold: arvalid=%b req_ready=%b, want 1/00", arvalid, req_ready);
    end
    step();
    arready = 1'b0;
    for (int b = 0; b < 16; b++) begin
      rvalid = 1'b1; rid = 4'd1; rresp = OKAY; rlast = (b == 15);
      rdata = 32'hA500_0000 + 32'(b);
      #1;
      n_tests++;
      if ({rready, resp_valid, resp_last, resp_err, resp_data} !==
          {1'b1, 2'b10, (b == 15) ? 2'b10 : 2'b00, 2'b00, 32'hA500_0000 + 32'(b)}) begin
        n_fail++;
        $display("FAIL single_beat%0d: rready=%b valid=%b last=%b err=%b data=%h, want 1/10/%s/00/%h", b,
                 rready, resp_valid, resp_last, resp_err, resp_data, (b == 15) ? "10" : "00", 32'hA500_0000 + 32'(b));
      end
      step();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    n_tests++;
    if ({rready, arvalid, proto_err, resp_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL single_end: rready=%b arvalid=%b proto_err=%b resp_valid=%b, want 0",
               rready, arvalid, proto_err, resp_valid);
    end
  endtask

  task automatic test_uncached_err();
    do_reset();
    set_req(0, 32'h4000_0010, 8'd0, 3'b001, BURST_FIXED);
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL unc_grant: req_ready=%b, want 01", req_ready);
    end
    step();
    req_valid = '0;
    arready = 1'b1;
    #1;
    n_tests++;
    if ({arvalid, arid, arlen, arsize, arburst} !== {1'b1, 4'd0, 8'd0, 3'b001, BURST_FIXED}) begin
      n_fail++;
      $display("FAIL unc_ar: got %h, want %h", {arvalid, arid, arlen, arsize, arburst},
               {1'b1, 4'd0, 8'd0, 3'b001, BURST_FIXED});
    end
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rlast = 1'b1; rresp = SLVERR; rdata = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if ({resp_valid, resp_last, resp_err, resp_data} !== {2'b01, 2'b01, 2'b01, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL unc_beat: valid=%b last=%b err=%b data=%h, want 01/01/01/deadbeef",
               resp_valid, resp_last, resp_err, resp_data);
    end
    step();
    clear_inputs();
    #1;
    n_tests++;
    if ({rready, proto_err, resp_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL unc_idle: rready=%b proto_err=%b resp_err=%b, want 0", rready, proto_err, resp_err);
    end
  endtask

  task automatic test_contention_drop();
    do_reset();
    set_req(0, 32'h0000_1000, 8'd1, 3'd2, BURST_INCR);
    set_req(1, 32'h0000_2000, 8'd0, 3'd2, BURST_INCR);
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL cont_first: req_ready=%b, want 01", req_ready);
    end
    step();
    req_valid[0] = 1'b0;
    arready = 1'b1;
    #1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rlast = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, resp_valid} !== {2'b00, 2'b01}) begin
      n_fail++;
      $display("FAIL cont_wait: req_ready=%b resp_valid=%b, want 00/01", req_ready, resp_valid);
    end
    step();
    rlast = 1'b1;
    #1;
    n_tests++;
    if ({req_ready, resp_last} !== {2'b00, 2'b01}) begin
      n_fail++;
      $display("FAIL cont_last: req_ready=%b resp_last=%b, want 00/01", req_ready, resp_last);
    end
    step();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL cont_second: req_ready=%b, want 10", req_ready);
    end
    step();
    req_valid = '0;
    #1;
    n_tests++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h0000_2000}) begin
      n_fail++;
      $display("FAIL cont_second_ar: got %h, want %h", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h0000_2000});
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd1; rlast = 1'b1;
    step();
    clear_inputs();
  endtask

  task automatic test_hold_both();
    int exp_ch;
    do_reset();
    set_req(0, 32'h0000_3000, 8'd0, 3'd2, BURST_INCR);
    set_req(1, 32'h0000_4000, 8'd0, 3'd2, BURST_INCR);
    for (int t = 0; t < 4; t++) begin
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
      exp_ch = t % 2;
`else
      exp_ch = 0;
`endif
      #1;
      n_tests++;
      if (req_ready !== ((exp_ch == 0) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL hold_grant%0d: req_ready=%b, want ch%0d", t, req_ready, exp_ch);
      end
      step();
      arready = 1'b1;
      step();
      arready = 1'b0;
      rvalid = 1'b1; rid = ID_W'(exp_ch); rlast = 1'b1;
      step();
      rvalid = 1'b0; rlast = 1'b0;
    end
    #1;
    n_tests++;
    if (proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_proto: proto_err=%b, want 0", proto_err);
    end
    clear_inputs();
  endtask

  task automatic test_proto_rid();
    do_reset();
    set_req(1, 32'h0000_5000, 8'd0, 3'd2, BURST_INCR);
    #1;
    step();
    req_valid = '0;
    arready = 1'b1;
    #1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd3; rlast = 1'b1;
    #1;
    n_tests++;
    if ({resp_valid, proto_err} !== {2'b10, 1'b0}) begin
      n_fail++;
      $display("FAIL rid_beat: resp_valid=%b proto_err=%b, want 10/0", resp_valid, proto_err);
    end
    step();
    clear_inputs();
    #1;
    n_tests++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rid_flag: proto_err=%b, want 1", proto_err);
    end
    step(); step(); step();
    n_tests++;
    if ({proto_err, rready} !== 2'b10) begin
      n_fail++;
      $display("FAIL rid_sticky: proto_err=%b rready=%b, want 1/0", proto_err, rready);
    end
  endtask

  task automatic test_proto_early_last();
    do_reset();
    set_req(0, 32'h0000_6000, 8'd15, 3'd2, BURST_INCR);
    #1;
    step();
    req_valid = '0;
    arready = 1'b1;
    #1;
    step();
    arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      rvalid = 1'b1; rid = 4'd0; rlast = (b == 3);
      #1;
      if (b == 3) begin
        n_tests++;
        if ({resp_last, proto_err} !== {2'b01, 1'b0}) begin
          n_fail++;
          $display("FAIL early_beat4: resp_last=%b proto_err=%b, want 01/0", resp_last, proto_err);
        end
      end
      step();
    end
    rvalid = 1'b0; rlast = 1'b0;
    set_req(1, 32'h0000_7000, 8'd0, 3'd2, BURST_INCR);
    #1;
    n_tests++;
    if ({proto_err, rready, req_ready} !== {1'b1, 1'b0, 2'b10}) begin
      n_fail++;
      $display("FAIL early_idle: proto_err=%b rready=%b req_ready=%b, want 1/0/10", proto_err, rready, req_ready);
    end
    clear_inputs();
  endtask

  task automatic test_overrun();
    do_reset();
    set_req(0, 32'h0000_8000, 8'd1, 3'd2, BURST_INCR);
    #1;
    step();
    req_valid = '0;
    arready = 1'b1;
    #1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rlast = 1'b0;
    step();
    #1;
    n_tests++;
    if ({proto_err, rready} !== 2'b01) begin
      n_fail++;
      $display("FAIL overrun_mid: proto_err=%b rready=%b, want 0/1", proto_err, rready);
    end
    step();
    rvalid = 1'b0;
    #1;
    n_tests++;
    if ({proto_err, rready} !== 2'b10) begin
      n_fail++;
      $display("FAIL overrun_exit: proto_err=%b rready=%b, want 1/0", proto_err, rready);
    end
  endtask

  task automatic test_rvalid_in_addr();
    do_reset();
    set_req(0, 32'h0000_9000, 8'd0, 3'd2, BURST_INCR);
    #1;
    step();
    req_valid = '0;
    rvalid = 1'b1; rid = 4'd0;
    #1;
    n_tests++;
    if ({arvalid, resp_valid, rready, resp_data} !== {1'b1, 2'b00, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL addr_rvalid_route: arvalid=%b resp_valid=%b rready=%b data=%h, want 1/00/0/0",
               arvalid, resp_valid, rready, resp_data);
    end
    step();
    rvalid = 1'b0;
    #1;
    n_tests++;
    if ({proto_err, arvalid} !== 2'b11) begin
      n_fail++;
      $display("FAIL addr_rvalid_flag: proto_err=%b arvalid=%b, want 1/1", proto_err, arvalid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(1, 32'h0000_A000, 8'd15, 3'd2, BURST_INCR);
    #1;
    step();
    req_valid = '0;
    arready = 1'b1;
    #1;
    step();
    arready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      rvalid = 1'b1; rid = 4'd1; rdata = 32'h5500_0000 + 32'(b);
      step();
    end
    rdata = 32'h5500_0005;
    req_valid = 2'b10;
    #1;
    n_tests++;
    if (resp_valid !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_pre: resp_valid=%b, want 10", resp_valid);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({req_ready, resp_valid, resp_last, resp_err, resp_data, arvalid, rready, proto_err,
         arid, araddr, arlen, arsize, arburst} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_zero: req_ready=%b resp_valid=%b data=%h arvalid=%b rready=%b araddr=%h arlen=%h, want 0",
               req_ready, resp_valid, resp_data, arvalid, rready, araddr, arlen);
    end
    step();
    rst = 1'b0;
    clear_inputs();
    set_req(1, 32'h0000_B000, 8'd3, 3'd2, BURST_WRAP);
    #1;
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_regrant: req_ready=%b, want 10", req_ready);
    end
    step();
    req_valid = '0;
    #1;
    n_tests++;
    if ({arvalid, arid, araddr, arlen, arburst} !== {1'b1, 4'd1, 32'h0000_B000, 8'd3, BURST_WRAP}) begin
      n_fail++;
      $display("FAIL rstmid_ar: got %h, want %h", {arvalid, arid, araddr, arlen, arburst},
               {1'b1, 4'd1, 32'h0000_B000, 8'd3, BURST_WRAP});
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single_burst();
    test_uncached_err();
    test_contention_drop();
    test_hold_both();
    test_proto_rid();
    test_proto_early_last();
    test_overrun();
    test_rvalid_in_addr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
